// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, instruction-memory
// request, a one-entry skid buffer and the IF/ID pipeline register. It honours
// the pcWrite/ifWrite enables from the load-use stall unit, flushes on
// branch/jump redirects, and feeds the IF/ID rs/rt fields back to the stall unit.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   pcWrite,
    input  logic                   ifWrite,
    input  logic                   branchTaken,
    input  logic [31:0]            branchTarget,
    input  logic                   jumpTaken,
    input  logic [31:0]            jumpTarget,
    output logic [31:0]            imemAddr,
    input  logic [31:0]            imemData,
    input  logic                   imemReady,
    output logic [31:0]            ifIdInstr,
    output logic [31:0]            ifIdPcPlus4,
    output logic                   ifIdValid,
    output logic [31:0]            ifIdRs,
    output logic [31:0]            ifIdRt,
    output logic [STALL_CNT_W-1:0] fetchStallCnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    logic [31:0] pc;
    logic [31:0] pcPlus4;

    // One-entry skid buffer: holds a fetched word when IF/ID is frozen but
    // the PC was still allowed to move on.
    logic        skidFull;
    logic [31:0] skidInstr;
    logic [31:0] skidPcPlus4;

    logic        redirect;
    logic [31:0] redirectTarget;
    logic        drainSkid;
    logic        captureIfId;
    logic        captureSkid;
    logic        bubbleIfId;
    logic        pcAdvance;

    assign imemAddr = pc;
    assign pcPlus4  = pc + 32'd4;

    assign ifIdRs = {27'b0, ifIdInstr[25:21]};
    assign ifIdRt = {27'b0, ifIdInstr[20:16]};

    // Decide this cycle's redirect target and which path (if any) consumes the fetched word.
    always_comb begin
        redirect       = branchTaken | jumpTaken;
        redirectTarget = (branchTaken ? branchTarget : jumpTarget) & 32'hFFFF_FFFC;

        // A full skid buffer must be emptied into IF/ID before a new memory
        // word is accepted, so the word on imemData is ignored while draining.
        drainSkid   = !redirect && skidFull && ifWrite;
        captureIfId = !redirect && !skidFull && ifWrite && imemReady;
        captureSkid = !redirect && !skidFull && !ifWrite && pcWrite && imemReady;
        bubbleIfId  = redirect || (!skidFull && ifWrite && !imemReady);

        // PC moves only when the current word lands somewhere; a full buffer
        // that is not draining forces the effective pcWrite low.
        pcAdvance   = pcWrite && (captureIfId || captureSkid);
    end

    // PC register: redirect first, then sequential advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirectTarget;
        end else if (pcAdvance) begin
            pc <= pcPlus4;
        end
    end

    // Skid buffer: fill when IF/ID is frozen, empty on drain or redirect.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            skidFull    <= 1'b0;
            skidInstr   <= 32'h0;
            skidPcPlus4 <= 32'h0;
        end else if (redirect || drainSkid) begin
            skidFull    <= 1'b0;
            skidInstr   <= 32'h0;
            skidPcPlus4 <= 32'h0;
        end else if (captureSkid) begin
            skidFull    <= 1'b1;
            skidInstr   <= imemData;
            skidPcPlus4 <= pcPlus4;
        end
    end

    // IF/ID register: buffered word has priority over memory, bubbles on
    // redirect or a missing fetch, and holds all fields when ifWrite is low.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            ifIdInstr   <= 32'h0;
            ifIdPcPlus4 <= 32'h0;
            ifIdValid   <= 1'b0;
        end else if (bubbleIfId) begin
            ifIdInstr   <= 32'h0;
            ifIdPcPlus4 <= 32'h0;
            ifIdValid   <= 1'b0;
        end else if (drainSkid) begin
            ifIdInstr   <= skidInstr;
            ifIdPcPlus4 <= skidPcPlus4;
            ifIdValid   <= 1'b1;
        end else if (captureIfId) begin
            ifIdInstr   <= imemData;
            ifIdPcPlus4 <= pcPlus4;
            ifIdValid   <= 1'b1;
        end
    end

    // Saturating count of cycles lost to memory wait states (redirect cycles excluded).
    always_ff @(posedge clk) begin
        if (!resetN) begin
            fetchStallCnt <= '0;
        end else if (!redirect && !imemReady && (fetchStallCnt != CNT_MAX)) begin
            fetchStallCnt <= fetchStallCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage. The driver issues one vector per
// cycle and pushes the hand-computed post-edge state into a queue; a monitor
// pops and compares one entry after every rising edge.
module tb_if_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcPlus4;
        logic        valid;
        int          cnt;
    } expectT;

    logic        clk;
    logic        resetN;
    logic        pcWrite;
    logic        ifWrite;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jumpTaken;
    logic [31:0] jumpTarget;
    logic [31:0] imemData;
    logic        imemReady;

    logic [31:0] imemAddr;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic [31:0] ifIdRs;
    logic [31:0] ifIdRt;
    logic [15:0] fetchStallCnt;

    logic [31:0] imemAddr4;
    logic [31:0] ifIdInstr4;
    logic [31:0] ifIdPcPlus44;
    logic        ifIdValid4;
    logic [31:0] ifIdRs4;
    logic [31:0] ifIdRt4;
    logic [3:0]  fetchStallCnt4;

    expectT expQ[$];
    int     errors = 0;
    int     checks = 0;

    if_fetch_stage #(.RESET_PC(32'h0), .STALL_CNT_W(16)) dut (
        .clk(clk), .resetN(resetN), .pcWrite(pcWrite), .ifWrite(ifWrite),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .jumpTaken(jumpTaken), .jumpTarget(jumpTarget),
        .imemAddr(imemAddr), .imemData(imemData), .imemReady(imemReady),
        .ifIdInstr(ifIdInstr), .ifIdPcPlus4(ifIdPcPlus4), .ifIdValid(ifIdValid),
        .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .fetchStallCnt(fetchStallCnt)
    );

    // Narrow-counter instance sharing all stimulus, used for saturation.
    if_fetch_stage #(.RESET_PC(32'h0), .STALL_CNT_W(4)) dut4 (
        .clk(clk), .resetN(resetN), .pcWrite(pcWrite), .ifWrite(ifWrite),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .jumpTaken(jumpTaken), .jumpTarget(jumpTarget),
        .imemAddr(imemAddr4), .imemData(imemData), .imemReady(imemReady),
        .ifIdInstr(ifIdInstr4), .ifIdPcPlus4(ifIdPcPlus44), .ifIdValid(ifIdValid4),
        .ifIdRs(ifIdRs4), .ifIdRt(ifIdRt4), .fetchStallCnt(fetchStallCnt4)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic applyStimulus(
        input logic rN, input logic pw, input logic iw,
        input logic bt, input logic [31:0] btg,
        input logic jt, input logic [31:0] jtg,
        input logic rdy, input logic [31:0] data,
        input logic [31:0] ePc, input logic [31:0] eInstr, input logic [31:0] eP4,
        input logic eV, input int eCnt);
        expectT e;
        @(negedge clk);
        resetN       = rN;
        pcWrite      = pw;
        ifWrite      = iw;
        branchTaken  = bt;
        branchTarget = btg;
        jumpTaken    = jt;
        jumpTarget   = jtg;
        imemReady    = rdy;
        imemData     = data;
        e.pc      = ePc;
        e.instr   = eInstr;
        e.pcPlus4 = eP4;
        e.valid   = eV;
        e.cnt     = eCnt;
        expQ.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 unit after the edge.
    always begin
        expectT e;
        int     cnt4;
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            cnt4 = (e.cnt > 15) ? 15 : e.cnt;
            checkOutput("imemAddr", imemAddr, e.pc);
            checkOutput("ifIdInstr", ifIdInstr, e.instr);
            checkOutput("ifIdPcPlus4", ifIdPcPlus4, e.pcPlus4);
            checkOutput("ifIdValid", {31'b0, ifIdValid}, {31'b0, e.valid});
            checkOutput("ifIdRs", ifIdRs, {27'b0, e.instr[25:21]});
            checkOutput("ifIdRt", ifIdRt, {27'b0, e.instr[20:16]});
            checkOutput("fetchStallCnt", {16'b0, fetchStallCnt}, 32'(e.cnt));
            checkOutput("fetchStallCnt4", {28'b0, fetchStallCnt4}, 32'(cnt4));
        end
    end

    // Directed scenario sequence followed by queue drain and summary.
    initial begin
        resetN = 1'b0; pcWrite = 1'b1; ifWrite = 1'b1;
        branchTaken = 1'b0; branchTarget = 32'h0;
        jumpTaken = 1'b0; jumpTarget = 32'h0;
        imemReady = 1'b1; imemData = 32'h0;

        // Reset for two cycles, then free-run
        applyStimulus(0,1,1, 0,0, 0,0, 1,32'h0,   32'h0,  32'h0,   32'h0, 0, 0);
        applyStimulus(0,1,1, 0,0, 0,0, 1,32'h0,   32'h0,  32'h0,   32'h0, 0, 0);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h100, 32'h4,  32'h100, 32'h4, 1, 0);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h104, 32'h8,  32'h104, 32'h8, 1, 0);

        // Load-use stall at pc=8, then resume with no duplicate or skip
        applyStimulus(1,0,0, 0,0, 0,0, 1,32'h108, 32'h8,  32'h104, 32'h8,  1, 0);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h108, 32'hC,  32'h108, 32'hC,  1, 0);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h10C, 32'h10, 32'h10C, 32'h10, 1, 0);

        // Skid buffer: fill, hold while full, drain, then continue
        applyStimulus(1,1,0, 0,0, 0,0, 1,32'h110, 32'h14, 32'h10C, 32'h10, 1, 0);
        applyStimulus(1,1,0, 0,0, 0,0, 1,32'h114, 32'h14, 32'h10C, 32'h10, 1, 0);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h114, 32'h14, 32'h110, 32'h14, 1, 0);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h114, 32'h18, 32'h114, 32'h18, 1, 0);

        // Memory wait states: three lost cycles, then resume at the same address
        applyStimulus(1,1,1, 0,0, 0,0, 0,32'h0,   32'h18, 32'h0,   32'h0,  0, 1);
        applyStimulus(1,1,1, 0,0, 0,0, 0,32'h0,   32'h18, 32'h0,   32'h0,  0, 2);
        applyStimulus(1,1,1, 0,0, 0,0, 0,32'h0,   32'h18, 32'h0,   32'h0,  0, 3);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h118, 32'h1C, 32'h118, 32'h1C, 1, 3);

        // Branch beats jump during a stall; target low bits cleared
        applyStimulus(1,0,0, 1,32'h43, 1,32'h80, 1,32'h11C, 32'h40, 32'h0, 32'h0, 0, 3);
        // Jump alone, with memory not ready: redirect cycle is not counted
        applyStimulus(1,1,1, 0,32'h0, 1,32'h87, 0,32'h0,    32'h84, 32'h0, 32'h0, 0, 3);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h184, 32'h88, 32'h184, 32'h88, 1, 3);

        // PC wrap from the top of the address space
        applyStimulus(1,1,1, 0,0, 1,32'hFFFF_FFFF, 1,32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 3);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 1, 3);

        // Long wait: the 4-bit counter sticks at 4'hF, the 16-bit one keeps counting
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1,1,1, 0,0, 0,0, 0,32'h0, 32'h0, 32'h0, 32'h0, 0, 3 + k);
        end

        // Reset asserted in the middle of a stall with a redirect pending
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h55, 32'h4, 32'h55, 32'h4, 1, 23);
        applyStimulus(1,0,0, 0,0, 0,0, 0,32'h0,  32'h4, 32'h55, 32'h4, 1, 24);
        applyStimulus(0,0,0, 1,32'h100, 0,0, 0,32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        applyStimulus(1,1,1, 0,0, 0,0, 1,32'h77, 32'h4, 32'h77, 32'h4, 1, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
